// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants and types for the seven-segment scan driver
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef logic [IDX_W-1:0] slot_t;
  typedef logic [6:0]       seg7_t;

  // Active-high {g,f,e,d,c,b,a} patterns
  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;
  localparam seg7_t SEG_BLANK = 7'h00;

  function automatic logic [NUM_DIGITS-1:0] slot_onehot(input slot_t i);
    return NUM_DIGITS'(1) << i;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - 4-bit code to active-high seven-segment pattern, invalid codes blank
module bcd_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] code,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_drv.sv
// rtl/seg_scan_drv.sv - four-digit multiplexed seven-segment scan driver with blanking and blink
module seg_scan_drv
  import seg_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 500,
  parameter int BLINK_FRAMES = 125,
  parameter int SEG_ACT_LOW  = 1,
  parameter int COM_ACT_LOW  = 1
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic [2:0]            d1,
  input  logic [3:0]            d2,
  input  logic [2:0]            d3,
  input  logic [3:0]            d4,
  input  logic                  lzb_en,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic                  colon_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] com,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD);
  localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);
  localparam slot_t         IDX_MAX  = slot_t'(NUM_DIGITS - 1);

  localparam seg7_t                 SEG_INV = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] COM_INV = (COM_ACT_LOW != 0) ? '1 : '0;

  logic [CW-1:0] cnt;
  slot_t         idx;
  logic [FW-1:0] fcnt;
  logic          ph;
  logic [2:0]    s1;
  logic [3:0]    s2;
  logic [2:0]    s3;
  logic [3:0]    s4;

  logic cnt_wrap;
  logic frame_wrap;
  logic snap;

  assign cnt_wrap   = (cnt == CNT_MAX);
  assign frame_wrap = cnt_wrap && (idx == IDX_MAX);
  assign snap       = (cnt == '0) && (idx == '0);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= '0;
      fcnt <= '0;
      ph   <= 1'b0;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      if (frame_wrap) begin
        if (fcnt == FCNT_MAX) begin
          fcnt <= '0;
          ph   <= ~ph;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  // Snapshot falls inside slot 0 dead time, so no lit slot mixes old and new digits
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
    end else if (snap) begin
      s1 <= d1;
      s2 <= d2;
      s3 <= d3;
      s4 <= d4;
    end
  end

  logic [3:0]            cur_code;
  seg7_t                 dec_seg;
  logic                  blank;
  seg7_t                 seg_int;
  logic                  dp_int;
  logic [NUM_DIGITS-1:0] com_int;

  always_comb begin
    cur_code = '0;
    case (idx)
      2'd0: cur_code = {1'b0, s1};
      2'd1: cur_code = s2;
      2'd2: cur_code = {1'b0, s3};
      default: cur_code = s4;
    endcase
  end

  bcd_to_seg7 u_dec (
    .code (cur_code),
    .seg  (dec_seg)
  );

  always_comb begin
    blank   = (lzb_en && (idx == '0) && (s1 == '0)) || (blink_mask[idx] && ph);
    seg_int = blank ? SEG_BLANK : dec_seg;
    dp_int  = (idx == slot_t'(1)) && colon_en && !ph;
    com_int = (cnt >= DEAD_END) ? slot_onehot(idx) : '0;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      seg         <= SEG_INV;
      dp          <= DP_INV;
      com         <= COM_INV;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_int ^ SEG_INV;
      dp          <= dp_int ^ DP_INV;
      com         <= com_int ^ COM_INV;
      frame_start <= snap;
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// tb/tb_seg_scan_drv.sv - scoreboard bench for seg_scan_drv
module tb_seg_scan_drv;

  localparam int SD = 8;
  localparam int DT = 2;
  localparam int BF = 2;

  logic       mclk = 1'b0;
  logic       rst_n;
  logic [2:0] d1;
  logic [3:0] d2;
  logic [2:0] d3;
  logic [3:0] d4;
  logic       lzb_en;
  logic [3:0] blink_mask;
  logic       colon_en;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] com;
  logic       frame_start;

  always #5 mclk = ~mclk;

  seg_scan_drv #(
    .SCAN_DIV     (SD),
    .DEAD         (DT),
    .BLINK_FRAMES (BF),
    .SEG_ACT_LOW  (0),
    .COM_ACT_LOW  (0)
  ) dut (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .lzb_en      (lzb_en),
    .blink_mask  (blink_mask),
    .colon_en    (colon_en),
    .seg         (seg),
    .dp          (dp),
    .com         (com),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic       fs;
    logic       dp;
    logic [3:0] com;
    logic [6:0] seg;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] msh [4];
  logic [6:0] pat [16];
  int         t;
  string      scen;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected outputs derived from the cycle count since reset release
  task automatic step();
    exp_t       e;
    int         c, sl, fr;
    logic       ph;
    c  = t % SD;
    sl = (t / SD) % 4;
    fr = t / (4 * SD);
    ph = ((fr / BF) % 2) == 1;
    e.com = (c >= DT) ? 4'(1 << sl) : 4'b0000;
    e.seg = pat[msh[sl]];
    if ((lzb_en && sl == 0 && msh[0] == 4'd0) || (blink_mask[sl] && ph)) e.seg = 7'h00;
    e.dp  = (sl == 1) && colon_en && !ph;
    e.fs  = (c == 0) && (sl == 0);
    sb.push_back(e);
    if (c == 0 && sl == 0) begin
      msh[0] = {1'b0, d1};
      msh[1] = d2;
      msh[2] = {1'b0, d3};
      msh[3] = d4;
    end
    @(posedge mclk);
    #1;
    e = sb.pop_front();
    check($sformatf("%s com t=%0d", scen, t), 16'(com), 16'(e.com));
    check($sformatf("%s seg t=%0d", scen, t), 16'(seg), 16'(e.seg));
    check($sformatf("%s dp t=%0d", scen, t), 16'(dp), 16'(e.dp));
    check($sformatf("%s fs t=%0d", scen, t), 16'(frame_start), 16'(e.fs));
    t++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic release_reset();
    @(negedge mclk);
    rst_n = 1'b1;
    t = 0;
    for (int i = 0; i < 4; i++) msh[i] = 4'd0;
  endtask

  initial begin
    pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    rst_n = 1'b0;
    d1 = 3'd1; d2 = 4'd2; d3 = 3'd3; d4 = 4'd4;
    lzb_en = 1'b0; blink_mask = 4'b0000; colon_en = 1'b0;
    scen = "reset";
    repeat (2) @(posedge mclk);
    #1;
    check("reset com", 16'(com), 16'h0);
    check("reset seg", 16'(seg), 16'h0);
    check("reset dp", 16'(dp), 16'h0);
    check("reset fs", 16'(frame_start), 16'h0);

    release_reset();
    scen = "scan";
    run(64);

    scen = "coherency";
    run(20);
    d2 = 4'd7;
    run(44);
    run(32);

    scen = "lzb_on";
    d1 = 3'd0;
    lzb_en = 1'b1;
    run(32);
    scen = "lzb_off";
    lzb_en = 1'b0;
    run(32);

    scen = "blink";
    d1 = 3'd1;
    blink_mask = 4'b0011;
    colon_en = 1'b1;
    run(256);

    scen = "invalid";
    blink_mask = 4'b0000;
    d4 = 4'hC;
    run(64);

    scen = "midreset";
    run(20);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset com", 16'(com), 16'h0);
    check("midreset seg", 16'(seg), 16'h0);
    check("midreset dp", 16'(dp), 16'h0);
    check("midreset fs", 16'(frame_start), 16'h0);
    repeat (2) @(posedge mclk);
    #1;
    check("midreset hold com", 16'(com), 16'h0);
    check("midreset hold seg", 16'(seg), 16'h0);
    release_reset();
    scen = "after_reset";
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
